// File: rtl/pwd_entry_ctrl.sv
// Password-entry controller: collects hex digits, checks them, grants access or locks out.
// Define PWD_MASK_EN to show 4'h8 instead of digit values during ENTRY and GRANTED.
module pwd_entry_ctrl #(
    parameter int DIGITS = 4,
    parameter logic [4*DIGITS-1:0] PASSWORD = 16'h1A2B,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 50_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       key_val,
    input  logic                             key_strobe,
    input  logic                             clr,
    output logic [4*DIGITS-1:0]              hex_out,
    output logic                             access_granted,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int W  = 4 * DIGITS;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [CW-1:0] CMAX = CW'(DIGITS);
    localparam logic [FW-1:0] FMAX = FW'(MAX_TRIES);
    localparam logic [LW-1:0] LMAX = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        GRANTED,
        DENIED,
        LOCKOUT
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  dbuf_q, dbuf_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [FW-1:0] fail_q, fail_nxt;
    logic [LW-1:0] lock_q, lock_nxt;

    logic [W-1:0]  hex_nxt;
    logic          grant_nxt;
    logic          lkout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ENTRY;
            dbuf_q         <= '0;
            cnt_q          <= '0;
            fail_q         <= '0;
            lock_q         <= '0;
            hex_out        <= '0;
            access_granted <= 1'b0;
            locked_out     <= 1'b0;
        end else begin
            state          <= state_nxt;
            dbuf_q         <= dbuf_nxt;
            cnt_q          <= cnt_nxt;
            fail_q         <= fail_nxt;
            lock_q         <= lock_nxt;
            hex_out        <= hex_nxt;
            access_granted <= grant_nxt;
            locked_out     <= lkout_nxt;
        end
    end

    assign fail_cnt = fail_q;

    always_comb begin
        state_nxt = state;
        dbuf_nxt  = dbuf_q;
        cnt_nxt   = cnt_q;
        fail_nxt  = fail_q;
        lock_nxt  = lock_q;
        unique case (state)
            ENTRY: begin
                if (clr) begin
                    dbuf_nxt = '0;
                    cnt_nxt  = '0;
                end else if (key_strobe) begin
                    dbuf_nxt = (dbuf_q << 4) | W'(key_val);
                    cnt_nxt  = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CMAX)
                        state_nxt = CHECK;
                end
            end
            CHECK: begin
                cnt_nxt = '0;
                if (dbuf_q == PASSWORD) begin
                    fail_nxt  = '0;
                    state_nxt = GRANTED;
                end else begin
                    fail_nxt  = fail_q + FW'(1);
                    state_nxt = (fail_q + FW'(1) == FMAX) ? LOCKOUT : DENIED;
                end
            end
            GRANTED, DENIED: begin
                if (clr) begin
                    dbuf_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ENTRY;
                end
            end
            LOCKOUT: begin
                if (lock_q == LMAX) begin
                    lock_nxt  = '0;
                    fail_nxt  = '0;
                    dbuf_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ENTRY;
                end else begin
                    lock_nxt = lock_q + LW'(1);
                end
            end
            default: state_nxt = ENTRY;
        endcase
    end

    // Outputs are computed from next-state values so they are registered yet aligned.
    always_comb begin
        hex_nxt   = '0;
        grant_nxt = (state_nxt == GRANTED);
        lkout_nxt = (state_nxt == LOCKOUT);
        unique case (state_nxt)
            DENIED:  hex_nxt = {DIGITS{4'hE}};
            LOCKOUT: hex_nxt = {DIGITS{4'hF}};
`ifdef PWD_MASK_EN
            GRANTED: hex_nxt = {DIGITS{4'h8}};
            CHECK:   hex_nxt = {DIGITS{4'h8}};
            default: begin
                for (int i = 0; i < DIGITS; i++)
                    hex_nxt[4*i +: 4] = (i < int'(cnt_nxt)) ? 4'h8 : 4'h0;
            end
`else
            default: hex_nxt = dbuf_nxt;
`endif
        endcase
    end

endmodule

// File: doc/pwd_entry_ctrl.md
# pwd_entry_ctrl

Password-entry controller for the password-gated memory access path. Collects hex digits from a one-cycle key strobe, compares the completed entry against a stored password, and grants or denies memory access. Enforces a lockout after repeated failures. Drives the per-digit hex nibbles consumed by the seven-segment display decoders downstream, one nibble per display digit.

## Interface
Parameters:
- DIGITS, 4, number of password digits and display nibbles.
- PASSWORD, 16'h1A2B, stored password, 4*DIGITS bits, most-significant nibble is the first digit entered.
- MAX_TRIES, 3, consecutive failures that trigger lockout.
- LOCK_CYCLES, 50_000_000, lockout duration in clk cycles.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- key_val  in  4  hex digit value, sampled only when key_strobe=1.
- key_strobe  in  1  one-cycle digit-entered pulse, already debounced and edge-detected upstream.
- clr  in  1  one-cycle pulse: abort entry, or exit GRANTED/DENIED.
- hex_out  out  4*DIGITS  display nibbles; [3:0] is the rightmost digit.
- access_granted  out  1  memory-access enable.
- locked_out  out  1  high during LOCKOUT.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed attempts.

## Operation
- States: ENTRY, CHECK, GRANTED, DENIED, LOCKOUT. Reset state is ENTRY.
- Reset values: hex_out=0, access_granted=0, locked_out=0, fail_cnt=0, digit buffer=0, digit count=0, lock counter=0.
- ENTRY:
  - Each key_strobe shifts key_val into the low nibble of the buffer; earlier digits move left. Digit count increments.
  - When the strobe brings the count to DIGITS, the next state is CHECK.
  - hex_out shows the buffer: entered digits occupy the low positions, unentered positions show 0.
- CHECK lasts exactly one cycle and compares the buffer against PASSWORD.
  - Match: go to GRANTED and clear fail_cnt.
  - Mismatch with fail_cnt+1 < MAX_TRIES: increment fail_cnt and go to DENIED.
  - Mismatch with fail_cnt+1 == MAX_TRIES: increment fail_cnt and go to LOCKOUT.
- GRANTED:
  - access_granted=1 and hex_out shows the entered password.
  - Holds until clr, which returns to ENTRY, clears the buffer and count, and drops access_granted.
- DENIED:
  - hex_out shows 4'hE on every digit.
  - Holds until clr, which returns to ENTRY with the buffer and count cleared. fail_cnt is retained.
- LOCKOUT:
  - locked_out=1 and hex_out shows 4'hF on every digit.
  - The lock counter counts LOCK_CYCLES cycles. After the final count, go to ENTRY and clear fail_cnt, the lock counter, the buffer and the count.
- Input priority and masking:
  - clr and key_strobe in the same cycle: clr wins and the digit is discarded.
  - clr in ENTRY clears the buffer and count and stays in ENTRY.
  - clr is ignored in LOCKOUT and CHECK.
  - key_strobe is ignored in CHECK, GRANTED, DENIED and LOCKOUT.
  - key_val is don't-care when key_strobe=0.
- rst asserted in any state returns all state and outputs to reset values at that edge. This includes an active lockout, which is abandoned.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- hex_out reflects a digit strobed at edge N starting after edge N.
- Final digit strobed at edge N:
  - state is CHECK after edge N;
  - GRANTED/DENIED/LOCKOUT is entered after edge N+1;
  - access_granted or locked_out is high after edge N+1.
- clr at edge N in GRANTED drops access_granted after edge N.
- LOCKOUT entered at edge M: locked_out is high for exactly LOCK_CYCLES cycles and low after edge M+LOCK_CYCLES.

## Configuration
- PWD_MASK_EN, when defined:
  - during ENTRY, each entered digit position on hex_out shows 4'h8 (all segments lit) instead of the digit value;
  - unentered positions still show 0;
  - in GRANTED, hex_out shows all 4'h8 instead of the password.
- PWD_MASK_EN undefined: digits are shown as entered, per Operation.
- Comparison logic is identical either way.

## Test plan
Bench parameters: defaults, with LOCK_CYCLES=8.
- Correct entry: strobe 1, A, 2, B.
  - hex_out=16'h1A2B.
  - access_granted=1 two cycles after the last strobe; fail_cnt=0.
  - clr then gives access_granted=0, hex_out=0.
- Wrong entry: strobe 1, 2, 3, 4.
  - DENIED, hex_out=16'hEEEE, fail_cnt=1, access_granted=0.
  - clr returns to ENTRY with fail_cnt still 1.
- Three consecutive wrong entries (with clr between):
  - locked_out=1 and hex_out=16'hFFFF for exactly 8 cycles.
  - Strobes and clr during lockout are ignored.
  - Then ENTRY with fail_cnt=0.
- Partial entry 1, A then clr, with a key_strobe in the same cycle as clr:
  - buffer cleared and the digit discarded.
  - A subsequent 1, A, 2, B grants access.
- rst asserted mid-lockout (cycle 3 of 8):
  - all outputs 0 after that edge and state ENTRY.
- With PWD_MASK_EN defined, strobe 1, A:
  - hex_out=16'h0088.
  - After the full correct entry, hex_out=16'h8888 and access_granted=1.
